// File: rtl/speed_tick_gen.sv
// rtl/speed_tick_gen.sv - run-time selectable row-advance timebase (optional SPEED_AUTORAMP_EN)
module speed_tick_gen #(
  parameter int NUM_SPEEDS = 8,
  parameter int SEL_W      = 3,
  parameter int BASE_DIV   = 6250000,
  parameter int CNT_W      = 32,
  parameter int ROW_W      = 4,
  parameter int RESET_SEL  = 7,
  parameter int RAMP_WRAPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  output logic             sel_ready,
  output logic [SEL_W-1:0] active_sel,
  output logic             tick,
  output logic [ROW_W-1:0] row,
  output logic             row_wrap
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_SPEEDS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = '1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_m1;
  logic [SEL_W-1:0] pending;
  logic [SEL_W-1:0] sel_clamped;
  logic             pend_v;
  logic             applied;
  logic             accept;
  logic             terminal;
  logic             apply;

`ifdef SPEED_AUTORAMP_EN
  localparam int RW_W = (RAMP_WRAPS < 2) ? 1 : $clog2(RAMP_WRAPS);
  logic [RW_W-1:0] wrap_cnt;
`endif

  // Period length tracks the speed that is currently timing rows.
  assign period_m1   = CNT_W'(BASE_DIV) * (CNT_W'(active_sel) + CNT_W'(1)) - CNT_W'(1);
  assign terminal    = en && (cnt == period_m1);
  assign accept      = sel_valid && sel_ready;
  assign sel_clamped = (sel > MAX_SEL) ? MAX_SEL : sel;
  // A paused timebase has no tick boundary to wait for, so apply at once.
  assign apply       = pend_v && (terminal || !en);

  // Speed request handshake: one request held at a time, ready returns after apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      pend_v    <= 1'b0;
      sel_ready <= 1'b1;
      applied   <= 1'b0;
    end else begin
      applied <= apply;
      if (accept) begin
        pending   <= sel_clamped;
        pend_v    <= 1'b1;
        sel_ready <= 1'b0;
      end else if (apply) begin
        pend_v <= 1'b0;
      end
      if (applied) begin
        sel_ready <= 1'b1;
      end
    end
  end

  // Prescaler, row index, pulses and active speed (handshake or auto-ramp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      active_sel <= SEL_W'(RESET_SEL);
      row        <= '0;
      tick       <= 1'b0;
      row_wrap   <= 1'b0;
`ifdef SPEED_AUTORAMP_EN
      wrap_cnt   <= '0;
`endif
    end else begin
      tick     <= 1'b0;
      row_wrap <= 1'b0;
      if (en) begin
        if (terminal) begin
          cnt      <= '0;
          tick     <= 1'b1;
          row      <= row + ROW_W'(1);
          row_wrap <= (row == ROW_MAX);
`ifdef SPEED_AUTORAMP_EN
          if (row == ROW_MAX) begin
            if (wrap_cnt == RW_W'(RAMP_WRAPS - 1)) begin
              wrap_cnt <= '0;
              // A request landing on the same edge takes priority over the ramp.
              if (!pend_v && active_sel != '0) begin
                active_sel <= active_sel - SEL_W'(1);
              end
            end else begin
              wrap_cnt <= wrap_cnt + RW_W'(1);
            end
          end
`endif
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (apply) begin
        cnt <= '0;
      end
      if (apply) begin
        active_sel <= pending;
      end
    end
  end

endmodule

// File: tb/tb_speed_tick_gen.sv
// tb/tb_speed_tick_gen.sv - directed self-checking bench for speed_tick_gen
module tb_speed_tick_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sel_valid = 1'b0;
  logic [2:0] sel = '0;
  logic       sel_ready;
  logic [2:0] active_sel;
  logic       tick;
  logic [3:0] row;
  logic       row_wrap;

  int checks = 0;
  int errors = 0;
  int n;
  int paused_ticks;
  logic [3:0] row_hold;

  speed_tick_gen #(
    .NUM_SPEEDS(6), .SEL_W(3), .BASE_DIV(4), .CNT_W(8),
    .ROW_W(4), .RESET_SEL(2), .RAMP_WRAPS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sel_valid(sel_valid), .sel(sel),
    .sel_ready(sel_ready), .active_sel(active_sel), .tick(tick),
    .row(row), .row_wrap(row_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts falling edges up to and including the one where tick is seen.
  task automatic wait_tick(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick && cyc < max);
  endtask

  task automatic wait_wrap(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!row_wrap && cyc < max);
    check("wrap_seen", row_wrap, 1);
  endtask

  task automatic send_req(input logic [2:0] s);
    sel_valid = 1'b1;
    sel = s;
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_tick", tick, 0);
    check("rst_row", row, 0);
    check("rst_wrap", row_wrap, 0);
    check("rst_ready", sel_ready, 1);
    check("rst_active", active_sel, 2);

    // 1: ticks every 12 cycles, row 1..15,0, wrap only on the 16th tick
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(100, n);
      check("t1_gap", n, 12);
      check("t1_row", row, k % 16);
      check("t1_wrap", row_wrap, (k == 16) ? 1 : 0);
    end

    // 2: request speed 0 at cnt=5
    repeat (5) @(negedge clk);
    send_req(3'd0);
    check("t2_ready_low", sel_ready, 0);
    check("t2_tick_one_cycle", tick, 0);
    wait_tick(100, n);
    check("t2_apply_gap", n, 6);
    check("t2_active", active_sel, 0);
    check("t2_ready_still_low", sel_ready, 0);
    @(negedge clk);
    check("t2_ready_back", sel_ready, 1);
    wait_tick(100, n);
    check("t2_fast_gap_a", n, 3);
    wait_tick(100, n);
    check("t2_fast_gap_b", n, 4);

    // 3: out-of-range request clamps to speed 5 (period 24)
    send_req(3'd7);
    check("t3_ready_low", sel_ready, 0);
    wait_tick(100, n);
    check("t3_apply_gap", n, 3);
    check("t3_active", active_sel, 5);
    wait_tick(100, n);
    check("t3_slow_gap_a", n, 24);
    // back to speed 2 for the pause scenario
    send_req(3'd2);
    wait_tick(100, n);
    check("t3_back_gap", n, 23);
    check("t3_back_active", active_sel, 2);

    // 4: pause at cnt=7 for 30 cycles
    @(negedge clk);
    check("t4_ready", sel_ready, 1);
    repeat (6) @(negedge clk);
    en = 1'b0;
    row_hold = row;
    paused_ticks = 0;
    repeat (30) begin
      @(negedge clk);
      if (tick) paused_ticks++;
    end
    check("t4_no_tick", paused_ticks, 0);
    check("t4_row_frozen", row, row_hold);
    en = 1'b1;
    wait_tick(100, n);
    check("t4_resume_gap", n, 5);
    // request while paused is applied on the next edge
    repeat (3) @(negedge clk);
    en = 1'b0;
    row_hold = row;
    send_req(3'd1);
    check("t4_pause_ready_low", sel_ready, 0);
    check("t4_pause_active_old", active_sel, 2);
    @(negedge clk);
    check("t4_pause_active_new", active_sel, 1);
    check("t4_pause_tick", tick, 0);
    check("t4_pause_row", row, row_hold);
    @(negedge clk);
    check("t4_pause_ready_back", sel_ready, 1);
    en = 1'b1;
    wait_tick(100, n);
    check("t4_cnt_cleared_gap", n, 8);

    // 5: reset with a request pending at cnt=9
    send_req(3'd3);
    wait_tick(100, n);
    check("t5_apply_gap", n, 7);
    check("t5_active", active_sel, 3);
    @(negedge clk);
    repeat (8) @(negedge clk);
    send_req(3'd0);
    check("t5_pending", sel_ready, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_active", active_sel, 2);
    check("t5_rst_row", row, 0);
    check("t5_rst_ready", sel_ready, 1);
    check("t5_rst_tick", tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(100, n);
    check("t5_after_rst_gap", n, 12);
    check("t5_pending_lost", active_sel, 2);

`ifdef SPEED_AUTORAMP_EN
    // 6: auto-ramp every 2 wraps, saturating at 0, request wins on ramp edge
    wait_wrap(1000, n);
    check("t6_w1_active", active_sel, 2);
    wait_wrap(1000, n);
    check("t6_w2_active", active_sel, 1);
    wait_tick(100, n);
    check("t6_gap_p8", n, 8);
    wait_wrap(1000, n);
    wait_wrap(1000, n);
    check("t6_w4_active", active_sel, 0);
    wait_tick(100, n);
    check("t6_gap_p4", n, 4);
    wait_wrap(1000, n);
    wait_wrap(1000, n);
    check("t6_w6_active", active_sel, 0);
    wait_wrap(1000, n);
    for (int k = 0; k < 20 && row != 4'd15; k++) wait_tick(100, n);
    check("t6_row15", row, 15);
    send_req(3'd4);
    wait_wrap(100, n);
    check("t6_req_wins_gap", n, 3);
    check("t6_req_wins", active_sel, 4);
`else
    // without auto-ramp the speed never changes on its own
    wait_wrap(1000, n);
    wait_wrap(1000, n);
    check("t6_no_ramp_active", active_sel, 2);
    wait_tick(100, n);
    check("t6_no_ramp_gap", n, 12);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
